// File: rtl/counter_scheduler.sv
// Arbitrates the shared game Counter between the debounced button (press timing,
// short/long classification) and the game FSM's fixed-length delay timer.
module counter_scheduler #(
  parameter int WIDTH       = 12,
  parameter int DELAY_TICKS = 1000
) (
  input  logic             clk_2K,
  input  logic             i_Reset,
  input  logic             i_BtnDeb,
  input  logic             i_BtnDown,
  input  logic             i_BtnUp,
  input  logic             i_DelayReq,
  input  logic [WIDTH-1:0] i_Count,
  input  logic             i_TwoSec,
  input  logic             i_RstOK,
  output logic             o_ActCounter,
  output logic             o_RstCounter,
  output logic             o_ShortPress,
  output logic             o_LongPress,
  output logic             o_DelayDone,
  output logic             o_Busy,
  output logic [1:0]       o_Owner
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_BTN_CNT,
    S_BTN_WAIT,
    S_DLY_CNT
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_BTN  = 2'b01,
    OWN_DLY  = 2'b10
  } owner_t;

  localparam logic [WIDTH-1:0] DELAY_CNT = WIDTH'(DELAY_TICKS);

  state_t state;
  owner_t owner;
  logic   btn_press;

  // A press only counts while the debounced level agrees the button is down.
  assign btn_press = i_BtnDown & ~i_BtnDeb;
  assign o_Owner   = owner;

  always_ff @(posedge clk_2K or negedge i_Reset) begin
    if (!i_Reset) begin
      state        <= S_IDLE;
      owner        <= OWN_NONE;
      o_ActCounter <= 1'b0;
      o_RstCounter <= 1'b0;
      o_ShortPress <= 1'b0;
      o_LongPress  <= 1'b0;
      o_DelayDone  <= 1'b0;
      o_Busy       <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle; a branch that fires overrides the
      // default with a later non-blocking write, so the last assignment wins.
      o_ShortPress <= 1'b0;
      o_LongPress  <= 1'b0;
      o_DelayDone  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (btn_press) begin
            state        <= S_CLR;
            owner        <= OWN_BTN;
            o_Busy       <= 1'b1;
            o_RstCounter <= 1'b1;
          end else if (i_DelayReq && !o_DelayDone) begin
            // The requester still holds i_DelayReq during the done pulse; skip it.
            state        <= S_CLR;
            owner        <= OWN_DLY;
            o_Busy       <= 1'b1;
            o_RstCounter <= 1'b1;
          end
        end

        S_CLR: begin
          if (i_RstOK) begin
            o_RstCounter <= 1'b0;
            o_ActCounter <= 1'b1;
            state        <= (owner == OWN_BTN) ? S_BTN_CNT : S_DLY_CNT;
          end
        end

        S_BTN_CNT: begin
          if (i_TwoSec) begin
            o_LongPress  <= 1'b1;
            o_ActCounter <= 1'b0;
            state        <= S_BTN_WAIT;
          end else if (i_BtnUp) begin
            o_ShortPress <= 1'b1;
            o_ActCounter <= 1'b0;
            o_Busy       <= 1'b0;
            owner        <= OWN_NONE;
            state        <= S_IDLE;
          end
        end

        S_BTN_WAIT: begin
          if (i_BtnDeb) begin
            o_Busy <= 1'b0;
            owner  <= OWN_NONE;
            state  <= S_IDLE;
          end
        end

        S_DLY_CNT: begin
          if (btn_press) begin
            // Button preempts; the still-pending delay restarts from zero later.
            o_ActCounter <= 1'b0;
            o_RstCounter <= 1'b1;
            owner        <= OWN_BTN;
            state        <= S_CLR;
          end else if (!i_DelayReq) begin
            o_ActCounter <= 1'b0;
            o_Busy       <= 1'b0;
            owner        <= OWN_NONE;
            state        <= S_IDLE;
          end else if (i_Count == DELAY_CNT) begin
            o_DelayDone  <= 1'b1;
            o_ActCounter <= 1'b0;
            o_Busy       <= 1'b0;
            owner        <= OWN_NONE;
            state        <= S_IDLE;
          end
        end

        default: begin
          o_ActCounter <= 1'b0;
          o_RstCounter <= 1'b0;
          o_Busy       <= 1'b0;
          owner        <= OWN_NONE;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule
